// File: rtl/pattern_loader_if.sv
// Grid initial-configuration write bundle shared by the preset loader and its user.
// Inputs: load request, pattern index, game-running flag; outputs: target cell
// address, write strobe, written value, busy and done status.
interface pattern_loader_if;
    logic       load;
    logic [1:0] pattern_sel;
    logic       enable_update;
    logic [7:0] row_select;
    logic [7:0] col_select;
    logic       set_initial;
    logic       cell_state;
    logic       busy;
    logic       done;

    // master: the loader (drives the grid write port)
    modport master (
        input  load, pattern_sel, enable_update,
        output row_select, col_select, set_initial, cell_state, busy, done
    );

    // slave: the requester / grid side
    modport slave (
        output load, pattern_sel, enable_update,
        input  row_select, col_select, set_initial, cell_state, busy, done
    );
endinterface

// File: rtl/pattern_loader.sv
// Preset-pattern loader: on a load rising edge clears all 256 grid cells, then
// writes one of four seed patterns one cell per clock, ending with a done pulse.
// Ports: clk (slow game clock), reset (async active-low), bus (pattern_loader_if.master).
module pattern_loader #(
    parameter int unsigned ORIGIN_ROW = 6,
    parameter int unsigned ORIGIN_COL = 6
) (
    input  logic              clk,
    input  logic              reset,
    pattern_loader_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WRITE, S_DONE} state_t;

    localparam logic [3:0] ORG_R = 4'(ORIGIN_ROW);
    localparam logic [3:0] ORG_C = 4'(ORIGIN_COL);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [1:0] pat_q, pat_d;
    logic       load_q;
    logic       start;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       set_q, set_d;
    logic       cell_q, cell_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] off;

    // Number of live cells in each seed pattern.
    function automatic logic [2:0] pat_len(input logic [1:0] p);
        case (p)
            2'd0:    pat_len = 3'd3;  // blinker
            2'd1:    pat_len = 3'd5;  // glider
            2'd2:    pat_len = 3'd4;  // block
            default: pat_len = 3'd6;  // toad
        endcase
    endfunction

    // Offset {dr[1:0], dc[1:0]} of cell i of pattern p, in issue order.
    function automatic logic [3:0] pat_off(input logic [1:0] p, input logic [2:0] i);
        case ({p, i})
            {2'd0, 3'd0}: pat_off = 4'b00_00;
            {2'd0, 3'd1}: pat_off = 4'b00_01;
            {2'd0, 3'd2}: pat_off = 4'b00_10;
            {2'd1, 3'd0}: pat_off = 4'b00_01;
            {2'd1, 3'd1}: pat_off = 4'b01_10;
            {2'd1, 3'd2}: pat_off = 4'b10_00;
            {2'd1, 3'd3}: pat_off = 4'b10_01;
            {2'd1, 3'd4}: pat_off = 4'b10_10;
            {2'd2, 3'd0}: pat_off = 4'b00_00;
            {2'd2, 3'd1}: pat_off = 4'b00_01;
            {2'd2, 3'd2}: pat_off = 4'b01_00;
            {2'd2, 3'd3}: pat_off = 4'b01_01;
            {2'd3, 3'd0}: pat_off = 4'b00_01;
            {2'd3, 3'd1}: pat_off = 4'b00_10;
            {2'd3, 3'd2}: pat_off = 4'b00_11;
            {2'd3, 3'd3}: pat_off = 4'b01_00;
            {2'd3, 3'd4}: pat_off = 4'b01_01;
            {2'd3, 3'd5}: pat_off = 4'b01_10;
            default:      pat_off = 4'b00_00;
        endcase
    endfunction

    // load_q resets to 0, so a load held high across reset release starts once.
    assign start = bus.load & ~load_q;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            pat_q   <= 2'd0;
            load_q  <= 1'b0;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            set_q   <= 1'b0;
            cell_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            load_q  <= bus.load;
            row_q   <= row_d;
            col_q   <= col_d;
            set_q   <= set_d;
            cell_q  <= cell_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state. idx counts clear cells (0..255) in CLEAR, pattern cells in WRITE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        case (state_q)
            S_IDLE: begin
                if (start && !bus.enable_update) begin
                    state_d = S_CLEAR;
                    idx_d   = 8'd0;
                    pat_d   = bus.pattern_sel;
                end
            end
            S_CLEAR: begin
                if (bus.enable_update) begin
                    state_d = S_IDLE;
                    idx_d   = 8'd0;
                end else if (idx_q == 8'd255) begin
                    state_d = S_WRITE;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_WRITE: begin
                if (bus.enable_update) begin
                    state_d = S_IDLE;
                    idx_d   = 8'd0;
                end else if (idx_q == {5'd0, pat_len(pat_q) - 3'd1}) begin
                    state_d = S_DONE;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered strobe for
    // a cell appears in the same cycle the FSM occupies that cell.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        set_d  = 1'b0;
        cell_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        off    = pat_off(pat_d, idx_d[2:0]);
        case (state_d)
            S_CLEAR: begin
                set_d  = 1'b1;
                busy_d = 1'b1;
                row_d  = idx_d[7:4];
                col_d  = idx_d[3:0];
            end
            S_WRITE: begin
                set_d  = 1'b1;
                cell_d = 1'b1;
                busy_d = 1'b1;
                // 4-bit sums wrap the pattern around the torus edges.
                row_d  = ORG_R + {2'b00, off[3:2]};
                col_d  = ORG_C + {2'b00, off[1:0]};
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.row_select  = {4'd0, row_q};
    assign bus.col_select  = {4'd0, col_q};
    assign bus.set_initial = set_q;
    assign bus.cell_state  = cell_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: two instances (origin 6,6 and 14,15), a
// shadow grid and write logs, hand-computed expected cell sequences and timing.
// Ports: none (top-level bench).
module tb_pattern_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_loader_if a_if ();
    pattern_loader_if b_if ();

    pattern_loader #(.ORIGIN_ROW(6), .ORIGIN_COL(6)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.master)
    );

    pattern_loader #(.ORIGIN_ROW(14), .ORIGIN_COL(15)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic       ga [16][16];
    logic [7:0] wr_a[$];
    logic [7:0] wr_b[$];
    int set_cnt_a, clr_cnt_a, clr_bad_a, busy_cnt_a, hi_bad;
    int done_cnt[2];
    int done_cyc[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_b.delete();
        set_cnt_a  = 0;
        clr_cnt_a  = 0;
        clr_bad_a  = 0;
        busy_cnt_a = 0;
        hi_bad     = 0;
    endtask

    function automatic int grid_pop();
        int n = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                if (ga[r][c]) n++;
        return n;
    endfunction

    // One clock: advance, then sample both DUTs 1 ns after the rising edge.
    task automatic tick();
        logic [7:0] rc;
        @(posedge clk);
        #1;
        cyc++;
        if (a_if.set_initial) begin
            set_cnt_a++;
            if (a_if.row_select[7:4] != 4'd0 || a_if.col_select[7:4] != 4'd0) hi_bad++;
            rc = {a_if.row_select[3:0], a_if.col_select[3:0]};
            ga[rc[7:4]][rc[3:0]] = a_if.cell_state;
            if (a_if.cell_state) wr_a.push_back(rc);
            else begin
                if (rc != clr_cnt_a[7:0]) clr_bad_a++;
                clr_cnt_a++;
            end
        end
        if (a_if.busy) busy_cnt_a++;
        if (a_if.done) begin done_cnt[0]++; done_cyc[0] = cyc; end
        if (b_if.set_initial) begin
            if (b_if.row_select[7:4] != 4'd0 || b_if.col_select[7:4] != 4'd0) hi_bad++;
            if (b_if.cell_state) wr_b.push_back({b_if.row_select[3:0], b_if.col_select[3:0]});
        end
        if (b_if.done) begin done_cnt[1]++; done_cyc[1] = cyc; end
    endtask

    task automatic wait_done(input int sel, input int budget, input string tag);
        int d0 = done_cnt[sel];
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt[sel] != d0) break;
        end
        check(tag, 32'(done_cnt[sel] != d0), 32'd1);
    endtask

    // exp holds the cells packed {row,col}, first issued cell in the top byte.
    task automatic cmp_writes(input int sel, input string tag, input logic [47:0] exp, input int n);
        int sz;
        logic [7:0] got;
        sz = (sel == 0) ? wr_a.size() : wr_b.size();
        check(tag, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            got = (sel == 0) ? wr_a[i] : wr_b[i];
            check(tag, {24'd0, got}, {24'd0, exp[8*(n-1-i) +: 8]});
        end
    endtask

    function automatic logic [19:0] out_vec_a();
        return {a_if.row_select, a_if.col_select, a_if.set_initial,
                a_if.cell_state, a_if.busy, a_if.done};
    endfunction

    int acc;
    int found;

    initial begin
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                ga[r][c] = 1'b0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        done_cyc[0] = 0; done_cyc[1] = 0;
        clear_logs();
        a_if.load = 1'b0; a_if.pattern_sel = 2'd0; a_if.enable_update = 1'b0;
        b_if.load = 1'b0; b_if.pattern_sel = 2'd1; b_if.enable_update = 1'b0;

        // Reset state
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("rst_async", {12'd0, out_vec_a()}, 32'd0);
        tick(); tick();
        check("rst_hold", {12'd0, out_vec_a()}, 32'd0);
        reset = 1'b1;
        tick();
        clear_logs();

        // Blinker at (6,6)
        a_if.load = 1'b1;
        tick();
        acc = cyc;
        check("blk_first", {27'd0, a_if.busy, a_if.set_initial, a_if.cell_state,
                            a_if.row_select[0], a_if.col_select[0]}, 32'b11000);
        wait_done(0, 400, "blk_done_to");
        check("blk_lat", 32'(done_cyc[0] - acc), 32'd259);
        check("blk_clr", 32'(clr_cnt_a), 32'd256);
        check("blk_order", 32'(clr_bad_a), 32'd0);
        cmp_writes(0, "blk_wr", {24'd0, 8'h66, 8'h67, 8'h68}, 3);
        check("blk_pop", 32'(grid_pop()), 32'd3);
        check("blk_cells", {29'd0, ga[6][6], ga[6][7], ga[6][8]}, 32'd7);
        check("blk_dn_cnt", 32'(done_cnt[0]), 32'd1);
        check("blk_dn_busy", {31'd0, a_if.busy}, 32'd0);
        tick();
        check("blk_after", {12'd0, out_vec_a()}, {12'd0, 8'd6, 8'd8, 4'b0000});
        a_if.load = 1'b0;

        // Glider at (14,15) with wraparound
        b_if.load = 1'b1;
        tick();
        check("gl_busy", {31'd0, b_if.busy}, 32'd1);
        wait_done(1, 400, "gl_done_to");
        cmp_writes(1, "gl_wr", {8'd0, 8'he0, 8'hf1, 8'h0f, 8'h00, 8'h01}, 5);
        check("hi_bits", 32'(hi_bad), 32'd0);
        b_if.load = 1'b0;
        tick();

        // Long load with a second edge while busy (block)
        clear_logs();
        a_if.pattern_sel = 2'd2;
        done_cnt[0] = 0;
        a_if.load = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 99)  a_if.load = 1'b0;
            if (i == 100) a_if.load = 1'b1;
        end
        a_if.load = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("hold_dn", 32'(done_cnt[0]), 32'd1);
        check("hold_clr", 32'(clr_cnt_a), 32'd256);
        check("hold_busy", 32'(busy_cnt_a), 32'd260);
        cmp_writes(0, "hold_wr", {16'd0, 8'h66, 8'h67, 8'h76, 8'h77}, 4);

        // Request while game running is ignored
        clear_logs();
        done_cnt[0] = 0;
        a_if.enable_update = 1'b1;
        a_if.load = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("en_set", 32'(set_cnt_a), 32'd0);
        check("en_busy", 32'(busy_cnt_a), 32'd0);
        a_if.load = 1'b0;
        tick();
        a_if.enable_update = 1'b0;
        tick();

        // Abort at clear index 50
        a_if.load = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_if.set_initial && clr_cnt_a == 51) begin found = 1; break; end
        end
        check("abort_reach", 32'(found), 32'd1);
        a_if.enable_update = 1'b1;
        tick();
        check("abort_out", {30'd0, a_if.set_initial, a_if.busy}, 32'd0);
        for (int i = 0; i < 300; i++) tick();
        check("abort_dn", 32'(done_cnt[0]), 32'd0);
        check("abort_clr", 32'(clr_cnt_a), 32'd51);
        a_if.enable_update = 1'b0;
        a_if.load = 1'b0;
        tick();

        // Reset mid-WRITE of toad, reload with load held
        clear_logs();
        a_if.pattern_sel = 2'd3;
        a_if.load = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (wr_a.size() == 2) break;
        end
        check("rw_reach", 32'(wr_a.size()), 32'd2);
        #2 reset = 1'b0;
        #1 check("rw_async", {12'd0, out_vec_a()}, 32'd0);
        tick();
        reset = 1'b1;
        clear_logs();
        done_cnt[0] = 0;
        tick();
        acc = cyc;
        check("rw_busy", {31'd0, a_if.busy}, 32'd1);
        wait_done(0, 400, "rw_done_to");
        check("rw_lat", 32'(done_cyc[0] - acc), 32'd262);
        cmp_writes(0, "rw_wr", {8'h67, 8'h68, 8'h69, 8'h76, 8'h77, 8'h78}, 6);
        check("rw_pop", 32'(grid_pop()), 32'd6);
        for (int i = 0; i < 10; i++) tick();
        check("rw_once", 32'(done_cnt[0]), 32'd1);
        a_if.load = 1'b0;
        tick();

        // pattern_sel changed during CLEAR has no effect
        clear_logs();
        a_if.pattern_sel = 2'd2;
        a_if.load = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        a_if.pattern_sel = 2'd3;
        wait_done(0, 400, "sel_done_to");
        cmp_writes(0, "sel_wr", {16'd0, 8'h66, 8'h67, 8'h76, 8'h77}, 4);
        a_if.load = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Preset-pattern loader upstream of the grid's initial-configuration write port.
- On a load request it clears all 256 cells, then writes one of four built-in seed patterns one cell per clock.
- It drives the same row_select/col_select/set_initial/new_state signals that userInput drives; the top level muxes the two sources using busy.
- It runs on the slow game clock, clk[slow].

Parameters:
ORIGIN_ROW, 6, grid row of pattern offset (0,0); 0..15
ORIGIN_COL, 6, grid column of pattern offset (0,0); 0..15

Ports:
clk            input   1  slow game clock; all state updates on rising edge
reset          input   1  asynchronous, active-low reset
load           input   1  level request; a rising edge starts a load
pattern_sel    input   2  pattern index; sampled when a load is accepted
enable_update  input   1  game-running flag from controlUnit
row_select     output  8  target row; bits [7:4] always 0
col_select     output  8  target column; bits [7:4] always 0
set_initial    output  1  write strobe to grid, one cell per cycle
cell_state     output  1  value written (0 = dead, 1 = alive)
busy           output  1  high in CLEAR and WRITE
done           output  1  one-cycle pulse when a load completes

Behaviour:
- All outputs are registered.
- Reset (reset = 0, asynchronous) forces: state IDLE; all outputs 0; load_q 0; index counters 0.
- Edge detect: load_q <= load each cycle; start = load & ~load_q.
  - Because load_q resets to 0, a load held high through reset release triggers exactly once.
- IDLE:
  - If start is high and enable_update is 0: latch pattern_sel, go to CLEAR, clear_idx = 0.
  - If start is high and enable_update is 1: ignore the request and stay in IDLE.
  - A rising edge of load seen in any state other than IDLE is ignored. No request is queued.
- CLEAR (256 cycles):
  - Outputs each cycle: set_initial = 1, cell_state = 0, row_select = clear_idx[7:4], col_select = clear_idx[3:0], busy = 1.
  - Order is row-major: (0,0), (0,1), …, (15,15).
  - After clear_idx = 255, go to WRITE with cell_idx = 0.
- WRITE (N cycles, N = cell count of the latched pattern):
  - Outputs each cycle: set_initial = 1, cell_state = 1, busy = 1.
  - row_select = (ORIGIN_ROW + dr) mod 16; col_select = (ORIGIN_COL + dc) mod 16. The wrap uses the low 4 bits.
  - Cells are issued in table order. After the last cell, go to DONE.
- DONE (1 cycle): done = 1, set_initial = 0, busy = 0; then return to IDLE.
- Timing: the first write is visible on the cycle after start is detected. Total from accept to the done pulse is 256 + N + 1 cycles.
- Abort: if enable_update goes to 1 during CLEAR or WRITE:
  - Next cycle: state IDLE, set_initial = 0, busy = 0.
  - No done pulse. Cells already written stay written.
- Reset during CLEAR or WRITE: immediate return to IDLE with outputs zeroed. The grid is left partially written.
- Pattern table, offsets (dr, dc) in issue order:
  - 0 blinker, N = 3: (0,0) (0,1) (0,2)
  - 1 glider, N = 5: (0,1) (1,2) (2,0) (2,1) (2,2)
  - 2 block, N = 4: (0,0) (0,1) (1,0) (1,1)
  - 3 toad, N = 6: (0,1) (0,2) (0,3) (1,0) (1,1) (1,2)
- Outside CLEAR and WRITE: set_initial = 0, cell_state = 0, row_select and col_select hold their last value.
- Changing pattern_sel while busy has no effect.

Test Plan:
- Reset then blinker: pattern_sel = 0, load 0→1 → busy = 1 the next cycle; 256 writes with cell_state = 0; then writes (6,6), (6,7), (6,8) with cell_state = 1; done pulses at cycle 260; a shadow 16×16 grid model has exactly those 3 cells set.
- Glider with ORIGIN_ROW = 14, ORIGIN_COL = 15 → wrapped writes (14,0), (15,1), (0,15), (0,0), (0,1); row_select[7:4] = 0 throughout.
- Load held high for 300 cycles, plus a second rising edge at cycle 100 while busy → exactly one load sequence and one done pulse.
- enable_update = 1 at the load edge → no set_initial, busy stays 0. enable_update raised at CLEAR index 50 → set_initial = 0 the next cycle, no done pulse.
- reset = 0 mid-WRITE (toad, after 2 cells) → all outputs 0 asynchronously. Release reset with load still high → one new full load (pattern_sel re-sampled), done after 263 cycles.
- pattern_sel changed from 2 to 3 during CLEAR → block cells (4 writes) are issued, not toad.
